// File: rtl/ps2_scancode_rx_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver: prefix bytes,
// deframer state encoding and the queued key-event layout.
package ps2_scancode_rx_pkg;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   // PS/2 frames carry odd parity across the eight data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Pin-side and consumer-side signals of the PS/2 receiver; master is the receiver,
// slave is whatever drives the PS/2 lines and consumes key events.
interface ps2_scancode_rx_if #(
   parameter int DEPTH = 8
);
   logic                     i_ps2_clk_n;
   logic                     i_ps2_dat;
   logic                     i_rd_en;
   logic                     i_clr_err;
   logic                     o_valid;
   logic [7:0]               o_code;
   logic                     o_ext;
   logic                     o_brk;
   logic [$clog2(DEPTH):0]   o_count;
   logic                     o_err_parity;
   logic                     o_err_frame;
   logic                     o_overflow;

   modport master (
      input  i_ps2_clk_n, i_ps2_dat, i_rd_en, i_clr_err,
      output o_valid, o_code, o_ext, o_brk, o_count,
             o_err_parity, o_err_frame, o_overflow
   );

   modport slave (
      output i_ps2_clk_n, i_ps2_dat, i_rd_en, i_clr_err,
      input  o_valid, o_code, o_ext, o_brk, o_count,
             o_err_parity, o_err_frame, o_overflow
   );
endinterface

// File: rtl/ps2_scancode_rx_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a write into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_pop  = rd_en && !empty;
   assign do_push = wr_en && ((count != FULL_CNT) || do_pop);
   assign drop    = wr_en && !do_push;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: line synchronisers, falling-edge strobe, 11-bit deframer,
// E0/F0 prefix folding and a show-ahead event FIFO with sticky error flags.
module ps2_scancode_rx
   import ps2_scancode_rx_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 50000
) (
   input  logic                clk,
   input  logic                i_arst_n,
   ps2_scancode_rx_if.master   bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

   logic [1:0]              rst_sync;
   logic                    rst_n;
   logic [SYNC_STAGES-1:0]  clk_sync;
   logic [SYNC_STAGES-1:0]  dat_sync;
   logic                    clk_prev;
   logic                    ps2_edge;
   logic                    dat_s;

   rx_state_t               state, state_nxt;
   logic [2:0]              bit_cnt;
   logic [7:0]              shift_q;
   logic                    par_q;
   logic [TMO_W-1:0]        tmo_cnt;
   logic                    tmo_hit, par_ok;
   logic                    shift_en, par_en, accept, bad_frame, set_perr, set_ferr;

   logic                    byte_vld_p0;
   logic [7:0]              byte_p0;
   logic                    ext_q, brk_q;
   logic                    is_prefix, push;
   key_event_t              push_ev, head;
   logic [9:0]              head_raw;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty, fifo_drop;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge i_arst_n) begin
      if (!i_arst_n) rst_sync <= '0;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.i_ps2_clk_n};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.i_ps2_dat};
         clk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end
   assign ps2_edge = clk_prev && !clk_sync[SYNC_STAGES-1];
   assign dat_s    = dat_sync[SYNC_STAGES-1];

   assign par_ok  = odd_parity_ok(shift_q, par_q);
   assign tmo_hit = (state != ST_IDLE) && !ps2_edge && (tmo_cnt == TMO_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      accept    = 1'b0;
      bad_frame = 1'b0;
      set_perr  = 1'b0;
      set_ferr  = 1'b0;
      if (tmo_hit) begin
         state_nxt = ST_IDLE;
         set_ferr  = 1'b1;
         bad_frame = 1'b1;
      end else if (ps2_edge) begin
         case (state)
            ST_IDLE: begin
               if (!dat_s) state_nxt = ST_DATA;
               else        set_ferr  = 1'b1;
            end
            ST_DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
               par_en    = 1'b1;
               state_nxt = ST_STOP;
            end
            ST_STOP: begin
               state_nxt = ST_IDLE;
               set_perr  = !par_ok;
               set_ferr  = !dat_s;
               accept    = par_ok && dat_s;
               bad_frame = !(par_ok && dat_s);
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         if (state == ST_IDLE) bit_cnt <= '0;
         else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
         if (ps2_edge || state == ST_IDLE) tmo_cnt <= '0;
         else                               tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) shift_q <= {dat_s, shift_q[7:1]};
      if (par_en)   par_q   <= dat_s;
   end

   // ---- stage p0: accepted byte registered, prefix folding and push ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) byte_vld_p0 <= 1'b0;
      else        byte_vld_p0 <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) byte_p0 <= shift_q;
   end

   assign is_prefix    = (byte_p0 == PS2_PFX_EXT) || (byte_p0 == PS2_PFX_BRK);
   assign push         = byte_vld_p0 && !is_prefix;
   assign push_ev.ext  = ext_q;
   assign push_ev.brk  = brk_q;
   assign push_ev.code = byte_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (bad_frame) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (byte_vld_p0) begin
         if (byte_p0 == PS2_PFX_EXT)      ext_q <= 1'b1;
         else if (byte_p0 == PS2_PFX_BRK) brk_q <= 1'b1;
         else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH ($bits(key_event_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data (push_ev),
      .rd_en   (bus.i_rd_en),
      .rd_data (head_raw),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .drop    (fifo_drop)
   );
   assign head = key_event_t'(head_raw);

   // A new error in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_err_parity <= 1'b0;
         bus.o_err_frame  <= 1'b0;
         bus.o_overflow   <= 1'b0;
      end else begin
         if (set_perr)           bus.o_err_parity <= 1'b1;
         else if (bus.i_clr_err) bus.o_err_parity <= 1'b0;
         if (set_ferr)           bus.o_err_frame  <= 1'b1;
         else if (bus.i_clr_err) bus.o_err_frame  <= 1'b0;
         if (fifo_drop)          bus.o_overflow   <= 1'b1;
         else if (bus.i_clr_err) bus.o_overflow   <= 1'b0;
      end
   end

   // Head fields are masked so the stale memory contents never reach the pins.
   assign bus.o_valid = !fifo_empty;
   assign bus.o_code  = fifo_empty ? 8'h00 : head.code;
   assign bus.o_ext   = !fifo_empty && head.ext;
   assign bus.o_brk   = !fifo_empty && head.brk;
   assign bus.o_count = fifo_count;

endmodule
